mm2s_stream_checker: RTL and testbench

// - Sink for the DataMover MM2S data stream, downstream of the S2MM/MM2S command sequencer.
// - Checks each read-back beat against the incrementing pattern written during the S2MM phase.
// - Checks frame boundaries (tlast), counts errors and latches the first failure.
// - Reports done/pass to the test controller.

---
 rtl/mm2s_stream_checker.sv | 133 +++++++++++++
 tb/tb_mm2s_stream_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s_stream_checker.sv
// Checks the MM2S read-back stream against an incrementing pattern and reports done/pass.
// Latency: err_count and first-error capture are registered, 1 cycle after the beat is accepted.
// Backpressure: tready is high throughout RUN, or LFSR-throttled (~75%) when CHK_BACKPRESSURE_EN is defined.
module mm2s_stream_checker #(
    parameter int                DATA_W      = 64,
    parameter int                FRAME_BYTES = 4096,
    parameter int                N_FRAMES    = 16,
    parameter logic [DATA_W-1:0] SEED        = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [31:0]           first_err_beat,
    output logic [DATA_W-1:0]     first_err_data
);

    localparam int                BPF       = FRAME_BYTES * 8 / DATA_W;
    localparam int                TOTAL     = N_FRAMES * BPF;
    localparam int                FC_W      = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [31:0]       LAST_BEAT = 32'(TOTAL - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(BPF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                clear;
    logic                accept;
    logic                beat_err;
    logic                bp_ok;
    logic [31:0]         beat_q;
    logic [FC_W-1:0]     fcnt_q;
    logic [DATA_W-1:0]   exp_q;
    logic                err_seen_q;

`ifdef CHK_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign bp_ok   = lfsr_q[0] | lfsr_q[1];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lfsr_q <= 16'hACE1;
        end else if (state_q == ST_RUN) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    assign bp_ok = 1'b1;
`endif

    assign s_axis_tready = (state_q == ST_RUN) && bp_ok;
    assign accept        = s_axis_tready && s_axis_tvalid;

    // Any combination of failures on one beat counts as a single errored beat.
    assign beat_err = (s_axis_tdata != exp_q)
                    || (s_axis_tkeep != {(DATA_W/8){1'b1}})
                    || (s_axis_tlast != (fcnt_q == FC_LAST));

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (beat_q == LAST_BEAT)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            beat_q         <= '0;
            fcnt_q         <= '0;
            exp_q          <= SEED;
            err_count      <= '0;
            first_err_beat <= '0;
            first_err_data <= '0;
            err_seen_q     <= 1'b0;
        end else if (accept) begin
            beat_q <= beat_q + 32'd1;
            fcnt_q <= (fcnt_q == FC_LAST) ? '0 : fcnt_q + FC_W'(1);
            exp_q  <= exp_q + DATA_W'(1);
            if (beat_err) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!err_seen_q) begin
                    err_seen_q     <= 1'b1;
                    first_err_beat <= beat_q;
                    first_err_data <= s_axis_tdata;
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_mm2s_stream_checker.sv
// Directed bench for mm2s_stream_checker: clean, corrupted, framing, gapped, restarted and reset runs.
module tb_mm2s_stream_checker;

    localparam int TOTAL = 8192;
    localparam int BPF   = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_beat;
    logic [63:0] first_err_data;

    int vectors    = 0;
    int miscompares = 0;
    int mon_acc    = 0;
    int rdy_low    = 0;

    // stream shaping knobs
    int          bad_data_k;
    logic [63:0] bad_data_val;
    int          miss_last_k;
    int          extra_last_k;
    int          restart_k;
    int          stop_k;
    bit          gaps;

    mm2s_stream_checker dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_beat (first_err_beat),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_axis_tvalid && s_axis_tready) mon_acc <= mon_acc + 1;
        if (busy && !s_axis_tready) rdy_low <= rdy_low + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_clean();
        bad_data_k   = -1;
        bad_data_val = '0;
        miss_last_k  = -1;
        extra_last_k = -1;
        restart_k    = -1;
        stop_k       = TOTAL;
        gaps         = 1'b0;
    endtask

    // entered and left at a negedge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_stream();
        int  k = 0;
        int  cyc = 0;
        bit  acc;
        bit  restarted = 1'b0;
        while (k < stop_k && cyc < 20000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tlast  = 1'($urandom);
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tkeep  = 8'hFF;
                s_axis_tdata  = (k == bad_data_k) ? bad_data_val : 64'(k);
                s_axis_tlast  = ((k % BPF) == BPF - 1);
                if (k == miss_last_k)  s_axis_tlast = 1'b0;
                if (k == extra_last_k) s_axis_tlast = 1'b1;
            end
            start = (k == restart_k) && !restarted;
            if (start) restarted = 1'b1;
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            if (acc) k++;
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("stream_complete", 64'(k), 64'(stop_k));
    endtask

    task automatic check_end(input logic [15:0] e_err, input logic e_pass);
        check("done", 64'(done), 64'd1);
        check("pass", 64'(pass), 64'(e_pass));
        check("err_count", 64'(err_count), 64'(e_err));
        check("busy_in_done", 64'(busy), 64'd0);
        check("tready_in_done", 64'(s_axis_tready), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_first_beat"}, 64'(first_err_beat), 64'd0);
        check({tag, "_first_data"}, first_err_data, 64'd0);
        check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    endtask

    initial begin
        int acc0;
        int low0;
        reset         = 1'b1;
        start         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // beats offered in IDLE are not accepted
        acc0 = mon_acc;
        s_axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tready", 64'(s_axis_tready), 64'd0);
        check("idle_no_accept", 64'(mon_acc - acc0), 64'd0);
        s_axis_tvalid = 1'b0;

        // clean run
        cfg_clean();
        acc0 = mon_acc;
        low0 = rdy_low;
        do_start();
        check("busy_after_start", 64'(busy), 64'd1);
        run_stream();
        check_end(16'd0, 1'b1);
        check("clean_accepted", 64'(mon_acc - acc0), 64'(TOTAL));
`ifdef CHK_BACKPRESSURE_EN
        check("tready_toggles", 64'(rdy_low - low0 > 0), 64'd1);
`else
        check("tready_steady", 64'(rdy_low - low0), 64'd0);
`endif

        // beats offered in DONE are not accepted; results hold
        acc0 = mon_acc;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hBAD;
        repeat (3) @(negedge clk);
        s_axis_tvalid = 1'b0;
        check("done_no_accept", 64'(mon_acc - acc0), 64'd0);
        check("done_hold_pass", 64'(pass), 64'd1);

        // data corruption at beat 100
        cfg_clean();
        bad_data_k   = 100;
        bad_data_val = 64'hDEAD;
        do_start();
        run_stream();
        check_end(16'd1, 1'b0);
        check("corrupt_first_beat", 64'(first_err_beat), 64'd100);
        check("corrupt_first_data", first_err_data, 64'hDEAD);

        // framing: missing tlast on 2047, extra on 2048
        cfg_clean();
        miss_last_k  = 2047;
        extra_last_k = 2048;
        do_start();
        run_stream();
        check_end(16'd2, 1'b0);
        check("frame_first_beat", 64'(first_err_beat), 64'd2047);
        check("frame_first_data", first_err_data, 64'd2047);

        // bad data and missing tlast on the same beat
        cfg_clean();
        bad_data_k   = 511;
        bad_data_val = 64'h1234;
        miss_last_k  = 511;
        do_start();
        run_stream();
        check_end(16'd1, 1'b0);
        check("both_first_beat", 64'(first_err_beat), 64'd511);
        check("both_first_data", first_err_data, 64'h1234);

        // random tvalid gaps and an ignored start at beat 3000
        cfg_clean();
        gaps      = 1'b1;
        restart_k = 3000;
        acc0 = mon_acc;
        do_start();
        run_stream();
        check_end(16'd0, 1'b1);
        check("gaps_accepted", 64'(mon_acc - acc0), 64'(TOTAL));

        // reset at beat 4000 with an error already captured
        cfg_clean();
        bad_data_k   = 10;
        bad_data_val = 64'hBEEF;
        stop_k       = 4000;
        do_start();
        run_stream();
        check("midrun_busy", 64'(busy), 64'd1);
        check("midrun_err_count", 64'(err_count), 64'd1);
        check("midrun_first_data", first_err_data, 64'hBEEF);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midrun_reset");

        cfg_clean();
        acc0 = mon_acc;
        do_start();
        run_stream();
        check_end(16'd0, 1'b1);
        check("post_reset_accepted", 64'(mon_acc - acc0), 64'(TOTAL));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
